// File: rtl/nec_ir_pkg.sv
// NEC IR transmitter shared definitions:
// state encoding, protocol unit counts and timing helpers.
package nec_ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_GAP
    } state_e;

    localparam int FRAME_W          = 32;
    localparam int UNIT_CNT_W       = 16;
    localparam int LEAD_MARK_UNITS  = 16;
    localparam int LEAD_SPACE_UNITS = 8;
    localparam int BIT_MARK_UNITS   = 1;
    localparam int ZERO_SPACE_UNITS = 1;
    localparam int ONE_SPACE_UNITS  = 3;
    localparam int STOP_MARK_UNITS  = 1;

    // Clocks per 562.5 us unit, never below one.
    function automatic int unit_ticks(input int clock_speed);
        longint t;
        t = longint'(clock_speed) * 9 / 16000;
        return (t < 1) ? 1 : int'(t);
    endfunction

    // Carrier half-period in clocks, never below one.
    function automatic int carrier_half(input int clock_speed, input int hz);
        int h;
        h = clock_speed / (2 * hz);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/nec_unit_timer.sv
// Free-running unit tick generator with synchronous restart;
// tick is high on the last clock of each unit.
module nec_unit_timer #(
    parameter int TICKS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Count clocks within a unit, wrapping on tick or restart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR frame transmitter: lead burst, 32 pulse-distance bits
// MSB first, stop burst, idle gap; carrier-modulated copy of envelope.
module nec_ir_transmitter
    import nec_ir_pkg::*;
#(
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int CARRIER_HZ  = 38_000,
    parameter int GAP_UNITS   = 16
) (
    input  logic               clkIN,
    input  logic               resetIN,
    input  logic               startIN,
    input  logic [FRAME_W-1:0] dataIN,
    output logic               busyOUT,
    output logic               doneOUT,
    output logic               txOUT,
    output logic               txModOUT
);

    localparam int UNIT_TICKS = unit_ticks(CLOCK_SPEED);
    localparam int HALF       = carrier_half(CLOCK_SPEED, CARRIER_HZ);
    localparam int CW         = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CLAST = CW'(HALF - 1);

    state_e                  state_q, state_d;
    logic [UNIT_CNT_W-1:0]   unit_q, unit_d, target;
    logic [5:0]              bit_q, bit_d;
    logic [FRAME_W-1:0]      data_q, data_d;
    logic [CW-1:0]           ccnt_q, ccnt_d;
    logic                    car_q, car_d;
    logic                    tx_q, tx_d, mod_q, mod_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    tick, restart, seg_end, cur_bit;

    nec_unit_timer #(.TICKS(UNIT_TICKS)) u_timer (
        .clk     (clkIN),
        .rst     (resetIN),
        .restart (restart),
        .tick    (tick)
    );

    assign cur_bit = data_q[bit_q[4:0]];
    assign restart = (state_d != state_q);
    assign seg_end = tick && (unit_q == target - 1'b1);

    // Length in units of the segment currently being sent.
    always_comb begin
        target = UNIT_CNT_W'(1);
        unique case (state_q)
            ST_LEAD_MARK:  target = UNIT_CNT_W'(LEAD_MARK_UNITS);
            ST_LEAD_SPACE: target = UNIT_CNT_W'(LEAD_SPACE_UNITS);
            ST_BIT_MARK:   target = UNIT_CNT_W'(BIT_MARK_UNITS);
            ST_BIT_SPACE:  target = cur_bit ? UNIT_CNT_W'(ONE_SPACE_UNITS)
                                            : UNIT_CNT_W'(ZERO_SPACE_UNITS);
            ST_STOP_MARK:  target = UNIT_CNT_W'(STOP_MARK_UNITS);
            ST_GAP:        target = UNIT_CNT_W'(GAP_UNITS);
            default:       target = UNIT_CNT_W'(1);
        endcase
    end

    // Next state, payload latch and bit selection.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: if (startIN) begin
                data_d  = dataIN;
                bit_d   = 6'(FRAME_W - 1);
                state_d = ST_LEAD_MARK;
            end
            ST_LEAD_MARK:  if (seg_end) state_d = ST_LEAD_SPACE;
            ST_LEAD_SPACE: if (seg_end) state_d = ST_BIT_MARK;
            ST_BIT_MARK:   if (seg_end) state_d = ST_BIT_SPACE;
            ST_BIT_SPACE: if (seg_end) begin
                if (bit_q == 6'd0) begin
                    state_d = ST_STOP_MARK;
                end else begin
                    bit_d   = bit_q - 6'd1;
                    state_d = ST_BIT_MARK;
                end
            end
            ST_STOP_MARK:  if (seg_end) state_d = ST_GAP;
            ST_GAP:        if (seg_end) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        unit_d = unit_q;
        if (restart || state_q == ST_IDLE) unit_d = '0;
        else if (tick)                     unit_d = unit_q + 1'b1;
    end

    // Outputs derived from the upcoming state, registered below.
    always_comb begin
        tx_d   = (state_d == ST_LEAD_MARK) || (state_d == ST_BIT_MARK) ||
                 (state_d == ST_STOP_MARK);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_GAP) && (state_d == ST_IDLE);
        car_d  = car_q;
        ccnt_d = ccnt_q;
        if (!tx_d) begin
            car_d  = 1'b0;
            ccnt_d = '0;
        end else if (!tx_q) begin
            car_d  = 1'b1;
            ccnt_d = '0;
        end else if (ccnt_q == CLAST) begin
            car_d  = ~car_q;
            ccnt_d = '0;
        end else begin
            ccnt_d = ccnt_q + 1'b1;
        end
        mod_d = tx_d & car_d;
    end

    // State and datapath registers.
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            state_q <= ST_IDLE;
            unit_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    // Registered outputs and carrier phase.
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            tx_q   <= 1'b0;
            mod_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            car_q  <= 1'b0;
            ccnt_q <= '0;
        end else begin
            tx_q   <= tx_d;
            mod_q  <= mod_d;
            busy_q <= busy_d;
            done_q <= done_d;
            car_q  <= car_d;
            ccnt_q <= ccnt_d;
        end
    end

    assign txOUT    = tx_q;
    assign txModOUT = mod_q;
    assign busyOUT  = busy_q;
    assign doneOUT  = done_q;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Testbench for nec_ir_transmitter: frame waveforms from a
// rule-based model, corner sequences and carrier timing.
module tb_nec_ir_transmitter;

    localparam int UT  = 9;
    localparam int UT2 = 427;

    typedef struct {
        logic [31:0] data;
        int          exp_len;
        bit          mid_pulse;
        bit          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] data;
    logic        busy, done, tx, txm;
    logic        rst2, start2;
    logic [31:0] data2;
    logic        busy2, done2, tx2, txm2;

    int  tests = 0;
    int  fails = 0;
    bit  wave[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    nec_ir_transmitter #(.CLOCK_SPEED(16000)) dut (
        .clkIN(clk), .resetIN(rst), .startIN(start), .dataIN(data),
        .busyOUT(busy), .doneOUT(done), .txOUT(tx), .txModOUT(txm)
    );

    nec_ir_transmitter #(.CLOCK_SPEED(760000), .CARRIER_HZ(38000)) dut2 (
        .clkIN(clk), .resetIN(rst2), .startIN(start2), .dataIN(data2),
        .busyOUT(busy2), .doneOUT(done2), .txOUT(tx2), .txModOUT(txm2)
    );

    task automatic check(input string name, input int k,
                         input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 25)
                $display("FAIL %s k=%0d got=%b want=%b", name, k, act, exp);
        end
    endtask

    function automatic void push(input int n, input bit v);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endfunction

    // Envelope of one frame, one entry per clock, from the protocol rules.
    function automatic void build_wave(input logic [31:0] d);
        wave.delete();
        push(16 * UT, 1'b1);
        push(8 * UT, 1'b0);
        for (int b = 31; b >= 0; b--) begin
            push(UT, 1'b1);
            push((d[b] ? 3 : 1) * UT, 1'b0);
        end
        push(UT, 1'b1);
        push(16 * UT, 1'b0);
    endfunction

    function automatic int frame_len(input logic [31:0] d);
        int ones = 0;
        for (int i = 0; i < 32; i++) if (d[i]) ones++;
        return (16 + 8 + 1 + 16 + 64 + 2 * ones) * UT;
    endfunction

    task automatic run_frame(input vec_t v, input bit rel_rst);
        @(negedge clk);
        if (rel_rst) rst = 1'b0;
        else check("idle_busy", -1, busy, 1'b0);
        data  = v.data;
        start = 1'b1;
        @(negedge clk);
        if (!v.hold) start = 1'b0;
        build_wave(v.data);
        for (int k = 0; k <= v.exp_len + 1; k++) begin
            if (k < v.exp_len) begin
                check("tx", k, tx, (k < wave.size()) ? wave[k] : 1'b0);
                check("busy", k, busy, 1'b1);
                check("done_early", k, done, 1'b0);
            end else if (k == v.exp_len) begin
                check("done", k, done, 1'b1);
                check("busy_end", k, busy, 1'b0);
                check("tx_end", k, tx, 1'b0);
            end else if (v.hold) begin
                check("rearm_tx", k, tx, 1'b1);
                check("rearm_busy", k, busy, 1'b1);
                check("rearm_done", k, done, 1'b0);
            end else begin
                check("done_once", k, done, 1'b0);
                check("idle_after", k, busy, 1'b0);
            end
            if (v.mid_pulse && k == 300) begin
                start = 1'b1;
                data  = ~v.data;
            end
            if (v.mid_pulse && k == 301) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; data = '0;
        rst2 = 1'b1; start2 = 1'b0; data2 = '0;

        tbl[0] = '{32'h0000_0000, 945, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 1521, 1'b0, 1'b0};
        tbl[2] = '{32'h8000_0001, 981, 1'b0, 1'b0};
        tbl[3] = '{32'hA5A5_A5A5, 1233, 1'b1, 1'b0};
        for (int i = 4; i < 7; i++) begin
            tbl[i].data      = $urandom;
            tbl[i].exp_len   = frame_len(tbl[i].data);
            tbl[i].mid_pulse = 1'b0;
            tbl[i].hold      = 1'b0;
        end
        tbl[7] = '{32'h1234_5678, 1179, 1'b0, 1'b1};

        #12;
        check("rst_busy", 0, busy, 1'b0);
        check("rst_done", 0, done, 1'b0);
        check("rst_tx", 0, tx, 1'b0);
        check("rst_txm", 0, txm, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(tbl[i], 1'b0);

        // Abort the re-armed frame, then abort a frame in its lead space.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        data  = 32'h0F0F_1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        check("lead_space_tx", 150, tx, 1'b0);
        check("lead_space_busy", 150, busy, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("abort_tx", 0, tx, 1'b0);
        check("abort_busy", 0, busy, 1'b0);
        check("abort_done", 0, done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            check("abort_no_done", k, done, 1'b0);
            check("abort_idle_tx", k, tx, 1'b0);
        end
        rst = 1'b1;
        v = '{32'hC3C3_0F0F, frame_len(32'hC3C3_0F0F), 1'b0, 1'b0};
        run_frame(v, 1'b1);

        // Carrier phase and envelope on the 760 kHz instance.
        @(negedge clk);
        rst2   = 1'b0;
        start2 = 1'b1;
        data2  = 32'h0;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 25 * UT2; k++) begin
            bit et, em;
            et = (k < 16 * UT2) || (k >= 24 * UT2);
            if (k < 16 * UT2)       em = ((k / 10) % 2) == 0;
            else if (k >= 24 * UT2) em = (((k - 24 * UT2) / 10) % 2) == 0;
            else                    em = 1'b0;
            check("car_tx", k, tx2, et);
            check("car_mod", k, txm2, em);
            @(negedge clk);
        end
        rst2 = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
